// File: rtl/cve2_ex_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// cve2_ex_issue_ctrl_if
//   Groups the handshake and data signals between ID/EX and the EX issue
//   controller.
//   master : the ID/EX side. It drives issue_valid_i, the decoded class,
//            flush_i, ex_valid_i and the imd write port, and it observes the
//            controller responses.
//   slave  : the issue controller, cve2_ex_issue_ctrl.
//   Signal names keep the controller's port names so that the mapping to the
//   original port list is one-to-one.
// ----------------------------------------------------------------------------
interface cve2_ex_issue_ctrl_if;
    logic        issue_valid_i;
    logic        instr_is_mult_i;
    logic        instr_is_div_i;
    logic        flush_i;
    logic        ex_valid_i;
    logic [1:0]  imd_val_we_i;
    logic [33:0] imd_val_d0_i;
    logic [33:0] imd_val_d1_i;

    logic [33:0] imd_val_q0_o;
    logic [33:0] imd_val_q1_o;
    logic        mult_en_o;
    logic        div_en_o;
    logic        mult_sel_o;
    logic        div_sel_o;
    logic        alu_instr_first_cycle_o;
    logic        issue_ready_o;
    logic        wb_valid_o;
    logic        stall_o;
    logic        illegal_o;
    logic        timeout_err_o;

    modport master (
        output issue_valid_i, instr_is_mult_i, instr_is_div_i, flush_i,
               ex_valid_i, imd_val_we_i, imd_val_d0_i, imd_val_d1_i,
        input  imd_val_q0_o, imd_val_q1_o, mult_en_o, div_en_o, mult_sel_o,
               div_sel_o, alu_instr_first_cycle_o, issue_ready_o, wb_valid_o,
               stall_o, illegal_o, timeout_err_o
    );

    modport slave (
        input  issue_valid_i, instr_is_mult_i, instr_is_div_i, flush_i,
               ex_valid_i, imd_val_we_i, imd_val_d0_i, imd_val_d1_i,
        output imd_val_q0_o, imd_val_q1_o, mult_en_o, div_en_o, mult_sel_o,
               div_sel_o, alu_instr_first_cycle_o, issue_ready_o, wb_valid_o,
               stall_o, illegal_o, timeout_err_o
    );
endinterface

// File: rtl/cve2_ex_issue_ctrl.sv
// ----------------------------------------------------------------------------
// vcve2_pkg : M-extension variant selector used by the issue controller.
//
// cve2_ex_issue_ctrl
//   Issue and retire control for the EX stage. A two-state FSM (IDLE/BUSY)
//   tracks multi-cycle instructions, and two 34-bit intermediate-value slots
//   are kept for the multi-cycle mult/div datapath.
//   Parameter RV32M : RV32MNone disables mult/div issue. A mult/div
//                     instruction is then retired as illegal.
//   Ports:
//     clk_i   clock, rising edge
//     rst_ni  asynchronous active-low reset
//     bus     cve2_ex_issue_ctrl_if.slave. It carries the issue handshake,
//             flush, EX valid, the imd write port, the imd read values, the
//             mult/div enables and selects, first-cycle, ready, writeback
//             valid, stall, illegal and timeout.
//   Optional feature, macro CVE2_EX_TIMEOUT_EN:
//     A 6-bit BUSY watchdog. When the count reaches 63 while EX is still not
//     valid, the instruction is aborted with a one-cycle timeout_err_o pulse.
//     Without the macro, timeout_err_o is tied low and BUSY waits
//     indefinitely.
// ----------------------------------------------------------------------------
package vcve2_pkg;
    typedef enum integer {
        RV32MNone        = 0,
        RV32MSlow        = 1,
        RV32MFast        = 2,
        RV32MSingleCycle = 3
    } rv32m_e;
endpackage

module cve2_ex_issue_ctrl #(
    parameter vcve2_pkg::rv32m_e RV32M = vcve2_pkg::RV32MFast
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    cve2_ex_issue_ctrl_if.slave bus
);

    localparam logic MdEnabled = (RV32M != vcve2_pkg::RV32MNone);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e      state_q;
    logic [33:0] imd_q [2];

    logic        md_req;
    logic        illegal_c;
    logic        timeout_c;
    logic        ready_c;
    logic        wb_c;
    logic        clear_imd;

    assign md_req    = bus.issue_valid_i & (bus.instr_is_mult_i | bus.instr_is_div_i);
    assign illegal_c = ~MdEnabled & md_req;

`ifdef CVE2_EX_TIMEOUT_EN
    logic [5:0] wd_q;

    assign timeout_c = (state_q == BUSY) & bus.issue_valid_i & ~bus.ex_valid_i &
                       ~bus.flush_i & (wd_q == 6'd63);
`else
    assign timeout_c = 1'b0;
`endif

    // Retire decision. Priority: flush, then the BUSY protocol error
    // (issue_valid_i dropped), then illegal, then timeout, then a normal EX
    // result.
    always_comb begin
        ready_c = 1'b0;
        wb_c    = 1'b0;
        if (bus.flush_i) begin
            ready_c = 1'b1;
        end else if (bus.issue_valid_i) begin
            if (illegal_c || timeout_c) begin
                ready_c = 1'b1;
            end else if (bus.ex_valid_i) begin
                ready_c = 1'b1;
                wb_c    = 1'b1;
            end
        end
    end

    assign clear_imd = bus.flush_i | timeout_c;

    // The selects are static data-mux controls and come straight from the
    // inputs. The remaining control outputs are forced low while reset is
    // asserted, so that an asynchronous reset quiets them at once.
    assign bus.mult_sel_o = MdEnabled & bus.issue_valid_i & bus.instr_is_mult_i;
    assign bus.div_sel_o  = MdEnabled & bus.issue_valid_i & bus.instr_is_div_i;
    assign bus.mult_en_o  = rst_ni & bus.mult_sel_o & ~bus.flush_i & ~timeout_c;
    assign bus.div_en_o   = rst_ni & bus.div_sel_o & ~bus.flush_i & ~timeout_c;

    assign bus.alu_instr_first_cycle_o = (state_q == IDLE) & bus.issue_valid_i;

    assign bus.issue_ready_o = rst_ni & ready_c;
    assign bus.wb_valid_o    = rst_ni & wb_c;
    assign bus.illegal_o     = rst_ni & illegal_c;
    assign bus.timeout_err_o = rst_ni & timeout_c;
    assign bus.stall_o       = bus.issue_valid_i & ~bus.issue_ready_o;

    assign bus.imd_val_q0_o = imd_q[0];
    assign bus.imd_val_q1_o = imd_q[1];

    // An instruction occupies EX across cycles only while it is offered and
    // not yet retired. Every other case, including flush, illegal, timeout and
    // a dropped issue_valid_i, lands in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < 2; k++) begin
                imd_q[k] <= '0;
            end
`ifdef CVE2_EX_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= (bus.issue_valid_i && !ready_c) ? BUSY : IDLE;

            if (clear_imd) begin
                for (int unsigned k = 0; k < 2; k++) begin
                    imd_q[k] <= '0;
                end
            end else if (bus.issue_valid_i) begin
                if (bus.imd_val_we_i[0]) imd_q[0] <= bus.imd_val_d0_i;
                if (bus.imd_val_we_i[1]) imd_q[1] <= bus.imd_val_d1_i;
            end

`ifdef CVE2_EX_TIMEOUT_EN
            if (state_q == IDLE) begin
                wd_q <= '0;
            end else if (!bus.ex_valid_i) begin
                wd_q <= wd_q + 6'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cve2_ex_issue_ctrl.sv
module tb_cve2_ex_issue_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cve2_ex_issue_ctrl_if bus();
    cve2_ex_issue_ctrl_if bus_n();

    cve2_ex_issue_ctrl #(.RV32M(vcve2_pkg::RV32MFast)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    cve2_ex_issue_ctrl #(.RV32M(vcve2_pkg::RV32MNone)) dut_none (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_n)
    );

    typedef struct packed {
        logic wb;
        logic ill;
        logic to;
        logic men;
        logic den;
    } ret_t;

    ret_t exp_q[$];
    ret_t exp_n_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic ret_t r(input logic wb, input logic ill, input logic to,
                               input logic men, input logic den);
        ret_t t;
        t.wb = wb; t.ill = ill; t.to = to; t.men = men; t.den = den;
        return t;
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check34(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check5(input string name, input ret_t act, input ret_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual{wb,ill,to,men,den}=%b required=%b at %0t",
                     name, act, req, $time);
        end
    endtask

    // Scoreboard monitors: each retire pulse pops one expected record.
    always @(negedge clk) begin : mon_main
        ret_t a;
        if (bus.issue_ready_o === 1'b1) begin
            a = r(bus.wb_valid_o, bus.illegal_o, bus.timeout_err_o, bus.mult_en_o, bus.div_en_o);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: actual=%b required=no retire at %0t", a, $time);
            end else begin
                check5("retire", a, exp_q.pop_front());
            end
        end else begin
            check1("wb_without_ready", bus.wb_valid_o, 1'b0);
        end
    end

    always @(negedge clk) begin : mon_none
        ret_t a;
        if (bus_n.issue_ready_o === 1'b1) begin
            a = r(bus_n.wb_valid_o, bus_n.illegal_o, bus_n.timeout_err_o,
                  bus_n.mult_en_o, bus_n.div_en_o);
            if (exp_n_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire_none: actual=%b required=no retire at %0t", a, $time);
            end else begin
                check5("retire_none", a, exp_n_q.pop_front());
            end
        end else begin
            check1("wb_without_ready_none", bus_n.wb_valid_o, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic m, input logic d,
                         input logic ex, input logic fl);
        bus.issue_valid_i   = iv;
        bus.instr_is_mult_i = m;
        bus.instr_is_div_i  = d;
        bus.ex_valid_i      = ex;
        bus.flush_i         = fl;
    endtask

    task automatic drive_n(input logic iv, input logic m, input logic d,
                           input logic ex, input logic fl);
        bus_n.issue_valid_i   = iv;
        bus_n.instr_is_mult_i = m;
        bus_n.instr_is_div_i  = d;
        bus_n.ex_valid_i      = ex;
        bus_n.flush_i         = fl;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin : stim
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive_n(0, 0, 0, 0, 0);
        bus.imd_val_we_i   = '0;
        bus.imd_val_d0_i   = '0;
        bus.imd_val_d1_i   = '0;
        bus_n.imd_val_we_i = '0;
        bus_n.imd_val_d0_i = '0;
        bus_n.imd_val_d1_i = '0;

        // Reset state
        #12;
        check1("rst_ready", bus.issue_ready_o, 1'b0);
        check1("rst_wb", bus.wb_valid_o, 1'b0);
        check1("rst_men", bus.mult_en_o, 1'b0);
        check1("rst_den", bus.div_en_o, 1'b0);
        check1("rst_illegal", bus.illegal_o, 1'b0);
        check1("rst_timeout", bus.timeout_err_o, 1'b0);
        check1("rst_stall", bus.stall_o, 1'b0);
        check34("rst_q0", bus.imd_val_q0_o, 34'h0);
        check34("rst_q1", bus.imd_val_q1_o, 34'h0);
        #1 rst_n = 1'b1;

        // ALU add: zero-latency retire, then again to show IDLE was kept.
        tick(); drive(1, 0, 0, 1, 0); exp_q.push_back(r(1, 0, 0, 0, 0));
        @(negedge clk);
        check1("alu_first", bus.alu_instr_first_cycle_o, 1'b1);
        check1("alu_stall", bus.stall_o, 1'b0);
        tick(); exp_q.push_back(r(1, 0, 0, 0, 0));
        @(negedge clk);
        check1("alu2_first", bus.alu_instr_first_cycle_o, 1'b1);
        tick(); drive(0, 0, 0, 0, 0);

        // MUL: EX valid in cycle 3.
        tick(); drive(1, 1, 0, 0, 0);
        @(negedge clk);
        check1("mul_c0_men", bus.mult_en_o, 1'b1);
        check1("mul_c0_first", bus.alu_instr_first_cycle_o, 1'b1);
        check1("mul_c0_stall", bus.stall_o, 1'b1);
        check1("mul_c0_ready", bus.issue_ready_o, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            @(negedge clk);
            check1("mul_busy_men", bus.mult_en_o, 1'b1);
            check1("mul_busy_first", bus.alu_instr_first_cycle_o, 1'b0);
            check1("mul_busy_stall", bus.stall_o, 1'b1);
        end
        tick(); bus.ex_valid_i = 1'b1; exp_q.push_back(r(1, 0, 0, 1, 0));
        @(negedge clk);
        check1("mul_c3_first", bus.alu_instr_first_cycle_o, 1'b0);
        check1("mul_c3_stall", bus.stall_o, 1'b0);
        tick(); drive(0, 0, 0, 0, 0);

        // DIV with imd writes, then flush.
        tick(); drive(1, 0, 1, 0, 0);
        @(negedge clk);
        check1("div_c0_den", bus.div_en_o, 1'b1);
        tick();
        bus.imd_val_we_i = 2'b11;
        bus.imd_val_d0_i = 34'h1_2345_6789;
        bus.imd_val_d1_i = 34'h0_0000_00FF;
        @(negedge clk);
        check34("div_c1_q0", bus.imd_val_q0_o, 34'h0);
        tick(); bus.imd_val_we_i = 2'b00;
        @(negedge clk);
        check34("div_c2_q0", bus.imd_val_q0_o, 34'h1_2345_6789);
        check34("div_c2_q1", bus.imd_val_q1_o, 34'h0_0000_00FF);
        check1("div_c2_den", bus.div_en_o, 1'b1);
        tick(); bus.flush_i = 1'b1; exp_q.push_back(r(0, 0, 0, 0, 0));
        @(negedge clk);
        check1("div_flush_den", bus.div_en_o, 1'b0);
        check34("div_c3_q0", bus.imd_val_q0_o, 34'h1_2345_6789);
        tick(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check34("div_c4_q0", bus.imd_val_q0_o, 34'h0);
        check34("div_c4_q1", bus.imd_val_q1_o, 34'h0);

        // Flush and EX valid in the same cycle: flush wins.
        tick(); drive(1, 1, 0, 0, 0);
        tick(); drive(1, 1, 0, 1, 1); exp_q.push_back(r(0, 0, 0, 0, 0));
        @(negedge clk);
        check1("flushex_men", bus.mult_en_o, 1'b0);
        tick(); drive(0, 0, 0, 0, 0);

        // BUSY with issue_valid_i dropped: no retire, back to IDLE.
        tick(); drive(1, 0, 0, 0, 0);
        @(negedge clk);
        check1("proto_stall", bus.stall_o, 1'b1);
        tick(); drive(0, 0, 0, 1, 0);
        @(negedge clk);
        check1("proto_ready", bus.issue_ready_o, 1'b0);
        tick(); drive(1, 0, 0, 1, 0); exp_q.push_back(r(1, 0, 0, 0, 0));
        @(negedge clk);
        check1("proto_idle_first", bus.alu_instr_first_cycle_o, 1'b1);
        tick(); drive(0, 0, 0, 0, 0);

        // RV32MNone: mult/div retire as illegal.
        tick(); drive_n(1, 1, 0, 0, 0); exp_n_q.push_back(r(0, 1, 0, 0, 0));
        @(negedge clk);
        check1("none_mul_sel", bus_n.mult_sel_o, 1'b0);
        check1("none_mul_stall", bus_n.stall_o, 1'b0);
        tick(); drive_n(1, 0, 1, 0, 0); exp_n_q.push_back(r(0, 1, 0, 0, 0));
        @(negedge clk);
        check1("none_div_sel", bus_n.div_sel_o, 1'b0);
        tick(); drive_n(1, 0, 0, 1, 0); exp_n_q.push_back(r(1, 0, 0, 0, 0));
        @(negedge clk);
        check1("none_alu_first", bus_n.alu_instr_first_cycle_o, 1'b1);
        tick(); drive_n(0, 0, 0, 0, 0);

        // DIV with EX valid never high.
        tick(); drive(1, 0, 1, 0, 0);
        @(negedge clk);
        check1("wd_c0_den", bus.div_en_o, 1'b1);
        for (int n = 1; n <= 63; n++) begin
            tick();
            @(negedge clk);
            check1("wd_no_timeout", bus.timeout_err_o, 1'b0);
        end
`ifdef CVE2_EX_TIMEOUT_EN
        tick(); exp_q.push_back(r(0, 0, 1, 0, 0));
        @(negedge clk);
        check1("wd_c64_timeout", bus.timeout_err_o, 1'b1);
        check1("wd_c64_den", bus.div_en_o, 1'b0);
        tick(); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check1("wd_c65_timeout", bus.timeout_err_o, 1'b0);
`else
        for (int n = 0; n < 8; n++) begin
            tick();
            @(negedge clk);
            check1("wd_off_timeout", bus.timeout_err_o, 1'b0);
            check1("wd_off_stall", bus.stall_o, 1'b1);
        end
        tick(); bus.flush_i = 1'b1; exp_q.push_back(r(0, 0, 0, 0, 0));
        tick(); drive(0, 0, 0, 0, 0);
`endif
        tick(); drive(1, 0, 0, 1, 0); exp_q.push_back(r(1, 0, 0, 0, 0));
        @(negedge clk);
        check1("wd_after_idle_first", bus.alu_instr_first_cycle_o, 1'b1);
        tick(); drive(0, 0, 0, 0, 0);

        // Asynchronous reset while BUSY in a DIV.
        tick(); drive(1, 0, 1, 0, 0);
        bus.imd_val_we_i = 2'b11;
        bus.imd_val_d0_i = 34'h2_AAAA_5555;
        bus.imd_val_d1_i = 34'h0_0000_0001;
        tick(); bus.imd_val_we_i = 2'b00;
        @(negedge clk);
        check34("rstmid_q0_before", bus.imd_val_q0_o, 34'h2_AAAA_5555);
        #2 rst_n = 1'b0;
        #1;
        check1("rstmid_ready", bus.issue_ready_o, 1'b0);
        check1("rstmid_wb", bus.wb_valid_o, 1'b0);
        check1("rstmid_den", bus.div_en_o, 1'b0);
        check34("rstmid_q0", bus.imd_val_q0_o, 34'h0);
        check34("rstmid_q1", bus.imd_val_q1_o, 34'h0);
        tick(); drive(0, 0, 0, 0, 0);
        tick(); rst_n = 1'b1;
        tick(); drive(1, 0, 0, 1, 0); exp_q.push_back(r(1, 0, 0, 0, 0));
        @(negedge clk);
        check1("rstmid_idle_first", bus.alu_instr_first_cycle_o, 1'b1);
        tick(); drive(0, 0, 0, 0, 0);

        repeat (3) tick();
        check34("pending_main", 34'(exp_q.size()), 34'h0);
        check34("pending_none", 34'(exp_n_q.size()), 34'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cve2_ex_issue_ctrl.md
CVE2_EX_ISSUE_CTRL -- requirements
Module: cve2_ex_issue_ctrl

Interface
REQ-001 Parameter RV32M, default vcve2_pkg::RV32MFast, M-extension variant; RV32MNone disables mult/div issue.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset; one clock, asynchronous, active-low.
REQ-004 issue_valid_i  in  1  ID has an instruction for EX; held high until issue_ready_o.
REQ-005 instr_is_mult_i / instr_is_div_i  in  1 each  decoded class, one-hot or both 0 (ALU).
REQ-006 flush_i  in  1  kill current instruction.
REQ-007 ex_valid_i  in  1  EX output valid this cycle.
REQ-008 imd_val_we_i  in  2  per-slot write enable from EX.
REQ-009 imd_val_d0_i / imd_val_d1_i  in  34 each  write data per slot.
REQ-010 imd_val_q0_o / imd_val_q1_o  out  34 each  registered intermediate values to EX.
REQ-011 mult_en_o / div_en_o  out  1 each  dynamic FSM enables to EX.
REQ-012 mult_sel_o / div_sel_o  out  1 each  static data-mux selects to EX.
REQ-013 alu_instr_first_cycle_o  out  1  first EX cycle of current instruction.
REQ-014 issue_ready_o  out  1  instruction retires from EX this cycle.
REQ-015 wb_valid_o  out  1  EX result valid for writeback this cycle.
REQ-016 stall_o  out  1  ID must hold: issue_valid_i & ~issue_ready_o.
REQ-017 illegal_o  out  1  mult/div issued with RV32M=RV32MNone.
REQ-018 timeout_err_o  out  1  watchdog abort pulse (Configuration).

Function
REQ-019 FSM states IDLE, BUSY; IDLE after reset.
REQ-020 mult_sel_o = issue_valid_i & instr_is_mult_i; div_sel_o likewise with instr_is_div_i; both 0 when RV32M=RV32MNone.
REQ-021 mult_en_o/div_en_o = corresponding sel & ~flush_i, in IDLE and BUSY.
REQ-022 alu_instr_first_cycle_o = 1 in IDLE when issue_valid_i, else 0.
REQ-023 IDLE, issue_valid_i, ex_valid_i, ~flush_i -> issue_ready_o=1, wb_valid_o=1, stay IDLE (zero added latency).
REQ-024 IDLE, issue_valid_i, ~ex_valid_i, ~flush_i -> BUSY next cycle.
REQ-025 BUSY, ex_valid_i, ~flush_i -> issue_ready_o=1, wb_valid_o=1, IDLE next cycle.
REQ-026 flush_i (any state) -> enables 0 same cycle, issue_ready_o=1, wb_valid_o=0, IDLE next cycle; both imd slots cleared to 0 next edge.
REQ-027 flush_i and ex_valid_i same cycle -> flush wins, wb_valid_o=0.
REQ-028 imd slot k written with imd_val_dk_i next edge when imd_val_we_i[k] & issue_valid_i & ~flush_i; else holds.
REQ-029 BUSY with issue_valid_i low is a protocol error; FSM returns IDLE, no retire pulse.
REQ-030 RV32MNone with instr_is_mult_i|instr_is_div_i -> illegal_o=1, issue_ready_o=1, wb_valid_o=0 same cycle, no enables, stay IDLE.
REQ-031 wb_valid_o never high without issue_ready_o.

Reset
REQ-032 rst_ni low: state IDLE, imd slots 0, watchdog count 0; all outputs 0 except those combinationally derived from inputs (sel, stall_o, first_cycle).
REQ-033 Reset mid-operation aborts without retire; first edge after release evaluates IDLE rules.

Configuration
REQ-034 Macro CVE2_EX_TIMEOUT_EN defined: 6-bit counter, cleared on entering BUSY, increments each BUSY cycle without ex_valid_i.
REQ-035 With macro: counter reaching 63 while BUSY and ~ex_valid_i -> timeout_err_o=1 and issue_ready_o=1 for one cycle, wb_valid_o=0, enables 0, imd slots cleared, IDLE next.
REQ-036 Without macro: no counter, timeout_err_o tied 0, BUSY waits indefinitely.

Verification
REQ-037 ALU add, issue_valid_i=1, ex_valid_i=1 in cycle 0 -> issue_ready_o=wb_valid_o=1 cycle 0, first_cycle=1, state IDLE.
REQ-038 MUL, ex_valid_i low cycles 0-2, high cycle 3 -> mult_en_o=1 cycles 0-3, first_cycle only cycle 0, retire cycle 3, stall_o=1 cycles 0-2.
REQ-039 DIV, imd_val_we_i=2'b11 with d0=34'h1_2345_6789, d1=34'h0_0000_00FF cycle 1 -> q outputs show values cycle 2; flush_i cycle 3 -> div_en_o=0 cycle 3, q outputs 0 cycle 4.
REQ-040 RV32MNone, MUL issued -> illegal_o=1, mult_en_o=0, issue_ready_o=1, wb_valid_o=0 same cycle.
REQ-041 CVE2_EX_TIMEOUT_EN, DIV with ex_valid_i never high -> timeout_err_o pulse 64 cycles after issue, IDLE next; without macro -> BUSY indefinitely, timeout_err_o=0.
REQ-042 rst_ni asserted asynchronously while BUSY mid-DIV -> outputs registered-0 immediately, IDLE after release, no wb_valid_o.
